// File: rtl/system_sequencer.sv
// system_sequencer: run controller sequencing IDLE -> LOADING -> EXECUTING -> HALTED.
// It owns the single RAM port and grants it to the loader, the CPU, then a debug reader.
//
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   start                 load+run request, honoured in IDLE or HALTED
//   loader_*              program loader handshake and RAM write channel
//   cpu_*                 CPU enable, RAM channel, PC and control state for halt detection
//   dbg_addr/dbg_rdata    debug read channel, live in HALTED
//   ram_*                 the shared RAM port
//   system_state, halted, timeout, access_violation, cycle_count   run status

module system_sequencer #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int HALT_CYCLES    = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  loader_start,
    input  logic                  loader_mem_write,
    input  logic [ADDR_WIDTH-1:0] loader_mem_addr,
    input  logic [DATA_WIDTH-1:0] loader_mem_wdata,
    input  logic                  loader_done,
    output logic                  cpu_run,
    input  logic                  cpu_mem_read,
    input  logic                  cpu_mem_write,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
    input  logic [DATA_WIDTH-1:0] cpu_mem_wdata,
    output logic [DATA_WIDTH-1:0] cpu_mem_rdata,
    input  logic [15:0]           cpu_pc,
    input  logic [2:0]            cpu_state,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [1:0]            system_state,
    output logic                  halted,
    output logic                  timeout,
    output logic                  access_violation,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam int SW = (HALT_CYCLES < 1) ? 1 : $clog2(HALT_CYCLES + 1);

    state_t               state;
    state_t               state_nxt;
    logic [15:0]          prev_pc;
    logic [SW-1:0]        stall_cnt;
    logic [SW-1:0]        stall_inc;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 start_ok;
    logic                 halt_hit;
    logic                 to_hit;
    logic                 violation;

    // Read strobe carries no information here: RAM reads are combinational.
    logic unused_rd;
    assign unused_rd = cpu_mem_read;

    assign system_state = state;
    assign halted       = (state == S_HALT);

    always_comb begin
        start_ok  = start && ((state == S_IDLE) || (state == S_HALT));
        stall_inc = '0;
        if ((cpu_state == 3'd0) && (cpu_pc == prev_pc))
            stall_inc = stall_cnt + 1'b1;
        // Saturating increment so a huge timeout never wraps the counter.
        cnt_inc   = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
        halt_hit  = (stall_inc == SW'(HALT_CYCLES));
        to_hit    = (cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES));
        violation = (loader_mem_write && (state != S_LOAD)) ||
                    (cpu_mem_write && (state != S_EXEC));
        state_nxt = state;
        unique case (state)
            S_IDLE, S_HALT: if (start_ok) state_nxt = S_LOAD;
            S_LOAD:         if (loader_done) state_nxt = S_EXEC;
            S_EXEC:         if (halt_hit || to_hit) state_nxt = S_HALT;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            loader_start     <= 1'b0;
            cpu_run          <= 1'b0;
            timeout          <= 1'b0;
            access_violation <= 1'b0;
            cycle_count      <= '0;
            prev_pc          <= 16'hFFFF;
            stall_cnt        <= '0;
        end else begin
            state        <= state_nxt;
            cpu_run      <= (state_nxt == S_EXEC);
            loader_start <= start_ok;
            if (start_ok) begin
                timeout          <= 1'b0;
                access_violation <= 1'b0;
                cycle_count      <= '0;
                stall_cnt        <= '0;
                prev_pc          <= 16'hFFFF;
            end else if (state == S_EXEC) begin
                cycle_count <= cnt_inc;
                stall_cnt   <= stall_inc;
                prev_pc     <= cpu_pc;
                // A stall halt on the same edge takes precedence.
                if (to_hit && !halt_hit)
                    timeout <= 1'b1;
            end
            if (violation)
                access_violation <= 1'b1;
        end
    end

    always_comb begin
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;
        cpu_mem_rdata = '0;
        dbg_rdata     = '0;
        unique case (state)
            S_LOAD: begin
                ram_we   = loader_mem_write;
                ram_addr = loader_mem_addr;
                if (loader_mem_write)
                    ram_wdata = loader_mem_wdata;
            end
            S_EXEC: begin
                ram_we        = cpu_mem_write;
                ram_addr      = cpu_mem_addr;
                cpu_mem_rdata = ram_rdata;
                if (cpu_mem_write)
                    ram_wdata = cpu_mem_wdata;
            end
            S_HALT: begin
                ram_addr  = dbg_addr;
                dbg_rdata = ram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_system_sequencer.sv
// tb_system_sequencer: vector table with a queued expectation per cycle,
// plus hand-built sequences for halt restart, timeout, tie and mid-run reset.

module tb_system_sequencer;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        loader_start;
    logic        loader_mem_write;
    logic [15:0] loader_mem_addr;
    logic [15:0] loader_mem_wdata;
    logic        loader_done;
    logic        cpu_run;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic [15:0] cpu_mem_addr;
    logic [15:0] cpu_mem_wdata;
    logic [15:0] cpu_mem_rdata;
    logic [15:0] cpu_pc;
    logic [2:0]  cpu_state;
    logic [15:0] dbg_addr;
    logic [15:0] dbg_rdata;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [1:0]  system_state;
    logic        halted;
    logic        timeout;
    logic        access_violation;
    logic [15:0] cycle_count;

    int checks = 0;
    int errors = 0;

    system_sequencer #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .HALT_CYCLES(5),
        .TIMEOUT_CYCLES(20), .CNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .loader_start(loader_start), .loader_mem_write(loader_mem_write),
        .loader_mem_addr(loader_mem_addr), .loader_mem_wdata(loader_mem_wdata),
        .loader_done(loader_done), .cpu_run(cpu_run),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_rdata(cpu_mem_rdata), .cpu_pc(cpu_pc), .cpu_state(cpu_state),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .system_state(system_state), .halted(halted), .timeout(timeout),
        .access_violation(access_violation), .cycle_count(cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Small RAM behind the port.
    logic        mem_clr;
    logic [15:0] mem [0:63];
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
        end else if (ram_we) begin
            mem[ram_addr[5:0]] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr[5:0]];

    typedef struct {
        logic        st, lw, cw, done;
        logic [2:0]  cs;
        logic [15:0] pc, addr, wd;
        logic        ewe;
        logic [15:0] eaddr, ewd, ecrd, edbg;
        logic [1:0]  es;
        logic        erun, els, eto, eav;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs [11];
    vec_t q [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        start            = 1'b0;
        loader_mem_write = 1'b0;
        loader_mem_addr  = 16'h0;
        loader_mem_wdata = 16'h0;
        loader_done      = 1'b0;
        cpu_mem_read     = 1'b0;
        cpu_mem_write    = 1'b0;
        cpu_mem_addr     = 16'h0;
        cpu_mem_wdata    = 16'h0;
        cpu_pc           = 16'h0;
        cpu_state        = 3'd1;
        dbg_addr         = 16'h0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic to_exec();
        clear_in();
        start = 1'b1;
        step();
        chk("load_state", 32'(system_state), 32'd1);
        clear_in();
        loader_done = 1'b1;
        step();
        chk("exec_state", 32'(system_state), 32'd2);
        chk("exec_run", 32'(cpu_run), 32'd1);
        clear_in();
    endtask

    // Runs EXECUTING with a PC pattern; n = edge on which HALTED appeared.
    task automatic run_exec(input int mode, output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            clear_in();
            cpu_state = 3'd0;
            case (mode)
                0:       cpu_pc = 16'd7;
                1:       cpu_pc = (k <= 5) ? 16'd7 : 16'd8;
                2:       cpu_pc = 16'(100 + k);
                default: cpu_pc = 16'(100 + ((k < 15) ? k : 15));
            endcase
            step();
            if (system_state == 2'd3) begin
                n = k;
                break;
            end
        end
        clear_in();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1);
    end

    initial begin
        int   n;
        vec_t v;
        vec_t e;

        //          st    lw    cw    done  cs    pc      addr     wd
        //          ewe   eaddr    ewd      ecrd     edbg
        //          es    run   ls    to    av    cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0,
                     1'b0, 16'h0, 16'h0, 16'h0, 16'h0,
                     2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 16'h3, 16'h1234,
                     1'b1, 16'h3, 16'h1234, 16'h0, 16'h0,
                     2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0, 16'h4, 16'h5678,
                     1'b1, 16'h4, 16'h5678, 16'h0, 16'h0,
                     2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h7, 16'h9, 16'hABCD,
                     1'b1, 16'h9, 16'hABCD, 16'h0, 16'h0,
                     2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h7, 16'h3, 16'h0,
                     1'b0, 16'h3, 16'h0, 16'h1234, 16'h0,
                     2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h7, 16'h9, 16'h0,
                     1'b0, 16'h9, 16'h0, 16'hABCD, 16'h0,
                     2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h7, 16'h4, 16'h0,
                     1'b0, 16'h4, 16'h0, 16'h5678, 16'h0,
                     2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h7, 16'h0, 16'h0,
                     1'b0, 16'h0, 16'h0, 16'h0, 16'h0,
                     2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h7, 16'h0, 16'hFFFF,
                     1'b0, 16'h0, 16'h0, 16'h0, 16'h0,
                     2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd6};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 16'h3, 16'h1111,
                     1'b0, 16'h3, 16'h0, 16'h0, 16'h1234,
                     2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd6};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0,
                     1'b0, 16'h0, 16'h0, 16'h0, 16'h0,
                     2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};

        // Reset
        clear_in();
        reset_n = 1'b0;
        mem_clr = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        mem_clr = 1'b0;
        #1;
        chk("rst_state", 32'(system_state), 32'd0);
        chk("rst_run", 32'(cpu_run), 32'd0);
        chk("rst_ls", 32'(loader_start), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_av", 32'(access_violation), 32'd0);
        chk("rst_cnt", 32'(cycle_count), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        step();

        // Loader write while IDLE is dropped and flagged
        clear_in();
        loader_mem_write = 1'b1;
        loader_mem_addr  = 16'h5;
        loader_mem_wdata = 16'h7777;
        #1;
        chk("idle_we", 32'(ram_we), 32'd0);
        chk("idle_wd", 32'(ram_wdata), 32'd0);
        step();
        chk("idle_av", 32'(access_violation), 32'd1);
        chk("idle_state", 32'(system_state), 32'd0);

        // Table: load, CPU run with stall halt, debug read, restart
        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            clear_in();
            start            = v.st;
            loader_mem_write = v.lw;
            cpu_mem_write    = v.cw;
            loader_done      = v.done;
            cpu_state        = v.cs;
            cpu_pc           = v.pc;
            loader_mem_addr  = v.addr;
            cpu_mem_addr     = v.addr;
            dbg_addr         = v.addr;
            loader_mem_wdata = v.wd;
            cpu_mem_wdata    = v.wd;
            q.push_back(v);
            #1;
            chk($sformatf("r%0d_we", i), 32'(ram_we), 32'(v.ewe));
            chk($sformatf("r%0d_addr", i), 32'(ram_addr), 32'(v.eaddr));
            chk($sformatf("r%0d_wd", i), 32'(ram_wdata), 32'(v.ewd));
            chk($sformatf("r%0d_crd", i), 32'(cpu_mem_rdata), 32'(v.ecrd));
            chk($sformatf("r%0d_dbg", i), 32'(dbg_rdata), 32'(v.edbg));
            @(posedge clock);
            #1;
            e = q.pop_front();
            chk($sformatf("r%0d_state", i), 32'(system_state), 32'(e.es));
            chk($sformatf("r%0d_run", i), 32'(cpu_run), 32'(e.erun));
            chk($sformatf("r%0d_ls", i), 32'(loader_start), 32'(e.els));
            chk($sformatf("r%0d_halted", i), 32'(halted),
                32'(e.es == 2'd3));
            chk($sformatf("r%0d_to", i), 32'(timeout), 32'(e.eto));
            chk($sformatf("r%0d_av", i), 32'(access_violation), 32'(e.eav));
            chk($sformatf("r%0d_cnt", i), 32'(cycle_count), 32'(e.ecnt));
        end

        // Stall restart: 4 stalls on PC 7, then PC 8 primes and stalls 5 times
        to_exec();
        run_exec(1, n);
        chk("restart_edges", 32'(n), 32'd11);
        chk("restart_to", 32'(timeout), 32'd0);
        chk("restart_cnt", 32'(cycle_count), 32'd11);
        chk("restart_halted", 32'(halted), 32'd1);

        // Timeout with an always-advancing PC
        to_exec();
        run_exec(2, n);
        chk("to_edges", 32'(n), 32'd20);
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_cnt", 32'(cycle_count), 32'd20);

        // Stall halt and timeout on the same edge
        to_exec();
        chk("to_cleared", 32'(timeout), 32'd0);
        run_exec(3, n);
        chk("tie_edges", 32'(n), 32'd20);
        chk("tie_flag", 32'(timeout), 32'd0);
        chk("tie_cnt", 32'(cycle_count), 32'd20);

        // Asynchronous reset in the middle of a run
        to_exec();
        cpu_state = 3'd0;
        cpu_pc    = 16'd50;
        step();
        cpu_pc    = 16'd51;
        step();
        reset_n = 1'b0;
        #1;
        chk("async_state", 32'(system_state), 32'd0);
        chk("async_run", 32'(cpu_run), 32'd0);
        chk("async_we", 32'(ram_we), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_state", 32'(system_state), 32'd0);
        to_exec();
        run_exec(0, n);
        chk("rerun_edges", 32'(n), 32'd6);
        chk("rerun_to", 32'(timeout), 32'd0);
        chk("rerun_cnt", 32'(cycle_count), 32'd6);
        dbg_addr = 16'h3;
        #1;
        chk("rerun_dbg", 32'(dbg_rdata), 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/system_sequencer.md
Name: system_sequencer

Overview:
- Top-level run controller for the 16-bit binary system. It sequences the IDLE, LOADING, EXECUTING and HALTED phases.
- It owns the single RAM port and hands it to the program loader, then to the CPU, then to a debug read port.
- It detects program completion by watching for a stalled PC, and enforces an execution timeout.
- It replaces the ad-hoc state and halt logic currently spread between the system top and the bench.

Parameters:
ADDR_WIDTH, 16, RAM address width
DATA_WIDTH, 16, RAM data width
HALT_CYCLES, 5, consecutive stalled fetch cycles that declare a halt
TIMEOUT_CYCLES, 1000, maximum EXECUTING cycles before a forced halt (must be ≥ 1)
CNT_WIDTH, 16, width of cycle_count

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request load+run; sampled in IDLE or HALTED only
loader_start  out  1  one-cycle pulse that launches the loader
loader_mem_write  in  1  loader RAM write strobe
loader_mem_addr  in  ADDR_WIDTH  loader write address
loader_mem_wdata  in  DATA_WIDTH  loader write data
loader_done  in  1  loader finished (level or pulse)
cpu_run  out  1  CPU clock-enable
cpu_mem_read  in  1  CPU read strobe
cpu_mem_write  in  1  CPU write strobe
cpu_mem_addr  in  ADDR_WIDTH  CPU address
cpu_mem_wdata  in  DATA_WIDTH  CPU write data
cpu_mem_rdata  out  DATA_WIDTH  RAM read data returned to the CPU
cpu_pc  in  16  CPU program counter
cpu_state  in  3  CPU control state; 0 = fetch
dbg_addr  in  ADDR_WIDTH  debug read address, used in HALTED
dbg_rdata  out  DATA_WIDTH  debug read data
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data
system_state  out  2  0 = IDLE, 1 = LOADING, 2 = EXECUTING, 3 = HALTED
halted  out  1  high in HALTED
timeout  out  1  sticky; the halt was caused by the timeout
access_violation  out  1  sticky; a write was attempted by a requester that does not own the port
cycle_count  out  CNT_WIDTH  EXECUTING cycles elapsed; saturates at all-ones

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE.
  - loader_start, cpu_run, halted, timeout, access_violation = 0; cycle_count = 0.
  - Internal: prev_pc = 16'hFFFF, stall_cnt = 0.
  - Reset mid-operation aborts immediately; RAM contents are untouched.
- FSM: all transitions are registered, so each takes effect one cycle after the condition is sampled.
  - IDLE: on start = 1, go to LOADING. loader_start = 1 for exactly the first LOADING cycle. Clear timeout, access_violation, cycle_count, stall_cnt; set prev_pc = 16'hFFFF.
  - LOADING: on loader_done = 1, go to EXECUTING. A loader write presented in the same cycle as loader_done is still performed. start is ignored.
  - EXECUTING: cpu_run = 1; cycle_count increments every cycle.
    - Each cycle: if cpu_state == 0 and cpu_pc == prev_pc, stall_cnt++; otherwise stall_cnt = 0. prev_pc <= cpu_pc every cycle.
    - When the incremented stall_cnt equals HALT_CYCLES, go to HALTED with timeout = 0.
    - Otherwise, when the incremented cycle_count equals TIMEOUT_CYCLES, go to HALTED with timeout = 1.
    - If both fire in the same cycle, the halt wins (timeout = 0).
    - start is ignored.
  - HALTED: cpu_run = 0, halted = 1. On start = 1, go to LOADING with the same clears as from IDLE.
- cpu_run is a registered output, high only while state == EXECUTING.
- RAM port mux (combinational from the registered state):
  - LOADING: ram_addr = loader_mem_addr, ram_wdata = loader_mem_wdata, ram_we = loader_mem_write.
  - EXECUTING: ram_addr = cpu_mem_addr, ram_wdata = cpu_mem_wdata, ram_we = cpu_mem_write; cpu_mem_rdata = ram_rdata.
  - HALTED: ram_addr = dbg_addr, ram_we = 0; dbg_rdata = ram_rdata.
  - IDLE: ram_addr = 0, ram_we = 0.
  - Everywhere else, cpu_mem_rdata = 0 and dbg_rdata = 0; ram_wdata = 0 whenever ram_we = 0.
- Ownership violations: a non-owner write strobe (loader_mem_write outside LOADING, cpu_mem_write outside EXECUTING) is dropped and sets access_violation on the next edge. It stays set until the next start is accepted.
- cycle_count holds its value in HALTED so the bench can read it after the run.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles, release → system_state = 0; cpu_run, halted, timeout, access_violation = 0; cycle_count = 0; ram_we = 0.
- Load: pulse start → next cycle system_state = 1 and loader_start = 1 for exactly 1 cycle. Loader writes addr 3 / data 16'h1234 → ram_we = 1, ram_addr = 3, ram_wdata = 16'h1234 in the same cycle. loader_done → system_state = 2 and cpu_run = 1 the following cycle.
- Halt detect: in EXECUTING drive cpu_state = 0 with cpu_pc fixed at 7 → system_state = 3 and halted = 1 exactly 6 edges after cpu_pc first equals 7 (1 priming edge + 5 stalls), timeout = 0. A PC change after 4 stalls restarts the count.
- Timeout: TIMEOUT_CYCLES = 20, PC incrementing every cycle → HALTED after 20 EXECUTING cycles with timeout = 1 and cycle_count = 20. Stall and timeout on the same edge → timeout = 0.
- Ownership: cpu_mem_write = 1 during LOADING → ram_we = 0 and access_violation = 1 next cycle. In HALTED, dbg_addr = 3 → dbg_rdata = 16'h1234. Then start → flags cleared, state = 1.
- Reset mid-run: drop reset_n while in EXECUTING → state = 0 and cpu_run = 0 immediately (async, before the next clock edge). A subsequent start reloads and runs normally.
